// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes,
// writeback FSM states and exception codes.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_DIV   = 4'h8;
  localparam logic [3:0] OP_ANDI  = 4'hC;
  localparam logic [3:0] OP_ORI   = 4'hE;
  localparam logic [3:0] OP_ADDNF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_MAIN,
    ST_WR_R0,
    ST_EXC
  } wb_state_e;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_ILL  = 2'b10;

endpackage

// File: rtl/alu_op_class.sv
// Opcode classifier: legality and whether
// the result also writes the R0 register.
module alu_op_class
  import cpu_pkg::*;
(
  input  logic [3:0] ctrl,
  output logic       legal,
  output logic       two_write
);

  // decode opcode class
  always_comb begin
    legal     = 1'b0;
    two_write = 1'b0;
    case (ctrl)
      OP_ADD, OP_SUB, OP_ANDI,
      OP_ORI, OP_ADDNF: legal = 1'b1;
      OP_MUL, OP_DIV: begin
        legal     = 1'b1;
        two_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results to
// the register file or raises an exception.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int R0_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [3:0]        ctrl,
  input  logic [REG_AW-1:0] dest,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_r0,
  input  logic              ovf,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              exc_valid,
  input  logic              exc_ready,
  output logic [1:0]        exc_code,
  output logic [3:0]        exc_ctrl,
  output logic [15:0]       retire_cnt
);

  wb_state_e state_q;
  wb_state_e state_d;

  logic legal;
  logic two_write;
  logic two_q;
  logic [DATA_W-1:0] r0_q;

  logic xfer;
  logic exc_hs;
  logic retire;

  logic              res_ready_d;
  logic              rf_we_d;
  logic [REG_AW-1:0] rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_d;
  logic              exc_valid_d;
  logic [1:0]        exc_code_d;
  logic [3:0]        exc_ctrl_d;

  alu_op_class u_class (
    .ctrl      (ctrl),
    .legal     (legal),
    .two_write (two_write)
  );

  assign xfer   = res_valid && res_ready;
  assign exc_hs = exc_valid && exc_ready;
  assign retire = (state_q == ST_WR_MAIN && !two_q)
               || (state_q == ST_WR_R0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (!legal || ovf) state_d = ST_EXC;
          else               state_d = ST_WR_MAIN;
        end
      end
      ST_WR_MAIN:
        state_d = two_q ? ST_WR_R0 : ST_IDLE;
      ST_WR_R0:
        state_d = ST_IDLE;
      ST_EXC:
        if (exc_hs) state_d = ST_IDLE;
    endcase
  end

  // next output values, keyed on next state
  always_comb begin
    res_ready_d = (state_d == ST_IDLE);
    rf_we_d     = 1'b0;
    rf_waddr_d  = '0;
    rf_wdata_d  = '0;
    exc_valid_d = (state_d == ST_EXC);
    exc_code_d  = EXC_NONE;
    exc_ctrl_d  = '0;
    unique case (state_d)
      ST_IDLE: ;
      ST_WR_MAIN: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = dest;
        rf_wdata_d = alu_out;
      end
      ST_WR_R0: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = REG_AW'(R0_ADDR);
        rf_wdata_d = r0_q;
      end
      ST_EXC: begin
        if (state_q == ST_IDLE) begin
          exc_code_d = legal ? EXC_OVF : EXC_ILL;
          exc_ctrl_d = ctrl;
        end else begin
          exc_code_d = exc_code;
          exc_ctrl_d = exc_ctrl;
        end
      end
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ready <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      exc_ctrl  <= '0;
    end else begin
      res_ready <= res_ready_d;
      rf_we     <= rf_we_d;
      rf_waddr  <= rf_waddr_d;
      rf_wdata  <= rf_wdata_d;
      exc_valid <= exc_valid_d;
      exc_code  <= exc_code_d;
      exc_ctrl  <= exc_ctrl_d;
    end
  end

  // capture second-write data on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      two_q <= 1'b0;
      r0_q  <= '0;
    end else if (xfer) begin
      two_q <= two_write;
      r0_q  <= alu_r0;
    end
  end

  // retired-result counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 16'd1;
  end

endmodule
